// File: rtl/injection_arbiter.sv
// Shares one NoC injection port between N_REQ stream sources: requester 0 (MA) must
// finish a non-empty boot stream first, then whole streams are granted round-robin.
module injection_arbiter #(
  parameter int N_REQ     = 2,
  parameter int FLIT_SIZE = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_tx_i,
  input  logic [N_REQ*FLIT_SIZE-1:0] req_data_i,
  output logic [N_REQ-1:0]           req_credit_o,
  output logic                       tx_o,
  input  logic                       credit_i,
  output logic [FLIT_SIZE-1:0]       data_o,
  output logic [N_REQ-1:0]           grant_o,
  output logic                       boot_done_o,
  output logic [31:0]                last_len_o
);

  localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {BOOT, IDLE, STREAM} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]        flit_cnt_q, flit_cnt_d;
  logic [31:0]        last_len_q, last_len_d;
  logic               boot_done_q, boot_done_d;

  logic               g_tx;
  logic [FLIT_SIZE-1:0] g_data;
  logic [N_REQ-1:0]   req_rot;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_off, rr_pick, rr_next;
  logic [IDX_W:0]     pick_sum, next_sum;

  always_comb begin
    g_tx   = 1'b0;
    g_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        g_tx   = req_tx_i[i];
        g_data = req_data_i[i*FLIT_SIZE +: FLIT_SIZE];
      end
    end
  end

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner offset.
  always_comb begin
    req_rot  = N_REQ'({req_tx_i, req_tx_i} >> rr_ptr_q);
    rr_found = 1'b0;
    rr_off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rr_found = 1'b1;
        rr_off   = IDX_W'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
    if (pick_sum >= (IDX_W+1)'(N_REQ)) pick_sum = pick_sum - (IDX_W+1)'(N_REQ);
    rr_pick  = pick_sum[IDX_W-1:0];
    next_sum = {1'b0, rr_pick} + (IDX_W+1)'(1);
    if (next_sum >= (IDX_W+1)'(N_REQ)) next_sum = '0;
    rr_next  = next_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BOOT;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      flit_cnt_q  <= '0;
      last_len_q  <= '0;
      boot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      flit_cnt_q  <= flit_cnt_d;
      last_len_q  <= last_len_d;
      boot_done_q <= boot_done_d;
    end
  end

  // A stream seen while boot_done_q is low can only have been started from BOOT.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    flit_cnt_d  = flit_cnt_q;
    last_len_d  = last_len_q;
    boot_done_d = boot_done_q;
    case (state_q)
      BOOT: begin
        if (req_tx_i[0]) begin
          grant_d = N_REQ'(1);
          gidx_d  = '0;
          state_d = STREAM;
        end
      end
      IDLE: begin
        if (rr_found) begin
          grant_d  = N_REQ'(1) << rr_pick;
          gidx_d   = rr_pick;
          rr_ptr_d = rr_next;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (!g_tx) begin
          grant_d    = '0;
          flit_cnt_d = '0;
          if (boot_done_q) begin
            state_d    = IDLE;
            last_len_d = flit_cnt_q;
          end else if (flit_cnt_q != '0) begin
            state_d     = IDLE;
            last_len_d  = flit_cnt_q;
            boot_done_d = 1'b1;
            rr_ptr_d    = IDX_W'(1);
          end else begin
            state_d = BOOT;
          end
        end else if (credit_i && (flit_cnt_q != '1)) begin
          flit_cnt_d = flit_cnt_q + 32'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign tx_o         = g_tx && (state_q == STREAM);
  assign data_o       = (state_q == STREAM) ? g_data : '0;
  assign req_credit_o = (state_q == STREAM) ? (grant_q & {N_REQ{credit_i}}) : '0;
  assign grant_o      = grant_q;
  assign boot_done_o  = boot_done_q;
  assign last_len_o   = last_len_q;

endmodule
